oc8051_branch_ctrl: RTL and testbench

Conditional-branch sequencer for the oc8051 core. It owns the condition comparator for JZ/JNZ/JC/JNC/JB/JNB/JBC and the DJNZ/CJNE "not-zero" branch. It drives the comparator's source select, waits for the operand to become valid, samples the comparator result, and computes the relative branch target. For a taken JBC it also sequences the bit-clear write-back. It sits between the decoder (which issues `start`) and the PC/write-back logic (which consume `done`, `take`, `target`, `bit_clr`).

---
 rtl/oc8051_branch_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_oc8051_branch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oc8051_branch_ctrl.sv
// ---------------------------------------------------------------------------
// oc8051_branch_ctrl
// Conditional-branch sequencer for the oc8051 core. Owns the condition
// comparator source select for JZ/JNZ/JC/JNC/JB/JNB/JBC and the DJNZ/CJNE
// "des != 0" branch, waits for the operand, samples the comparator result,
// computes the relative branch target and, for a taken JBC, sequences the
// bit-clear write-back.
//
// Ports
//   clk_i        core clock
//   rst_n_i      asynchronous active-low reset
//   start_i      one-cycle request, sampled only in IDLE
//   op_i[2:0]    0 JZ,1 JNZ,2 JC,3 JNC,4 JB,5 JNB,6 JBC,7 JDES
//   rel_i[7:0]   signed branch offset, captured with start_i
//   pc_i[15:0]   address of next instruction, captured with start_i
//   comp_sel_o   comparator source: 00 AZ, 01 DES, 10 CY, 11 BIT
//   eq_i         comparator result
//   opnd_vld_i   bit/des operand valid (operand-class ops)
//   clr_ack_i    bit-clear write accepted
//   busy_o       sequence in progress
//   done_o       one-cycle completion pulse
//   take_o       branch taken (held until the next completion)
//   target_o     pc + sign-extended rel (held like take_o)
//   bit_clr_o    request clear of the tested bit, held until clr_ack_i
//   err_o        timeout abort flag (held like take_o)
//
// Configuration
//   OC8051_BRANCH_TIMEOUT_EN : when defined, WAIT and CLR abort after
//   TIMEOUT cycles (1..15) without opnd_vld_i / clr_ack_i. When undefined
//   there is no counter, both states wait indefinitely and err_o stays 0.
// ---------------------------------------------------------------------------
module oc8051_branch_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [7:0]  rel_i,
   input  logic [15:0] pc_i,
   output logic [1:0]  comp_sel_o,
   input  logic        eq_i,
   input  logic        opnd_vld_i,
   input  logic        clr_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        take_o,
   output logic [15:0] target_o,
   output logic        bit_clr_o,
   output logic        err_o
);

   localparam logic [2:0] OP_JZ  = 3'd0;
   localparam logic [2:0] OP_JC  = 3'd2;
   localparam logic [2:0] OP_JB  = 3'd4;
   localparam logic [2:0] OP_JBC = 3'd6;
   localparam logic [2:0] OP_JDES = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_WAIT = 3'd2,
      ST_CLR  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // An out-of-range TIMEOUT shows up as this named scope in the elaborated design.
   if ((TIMEOUT < 1) || (TIMEOUT > 15)) begin : g_timeout_out_of_range
   end

   // Comparator source for an opcode.
   function automatic logic [1:0] sel_of(input logic [2:0] op);
      logic [1:0] sel;
      case (op)
         3'd0, 3'd1: sel = 2'b00;
         3'd2, 3'd3: sel = 2'b10;
         OP_JDES:    sel = 2'b01;
         default:    sel = 2'b11;
      endcase
      return sel;
   endfunction

   // Branch decision: positive-sense ops branch on eq, the rest on !eq.
   function automatic logic take_of(input logic [2:0] op, input logic eq);
      logic tk;
      case (op)
         OP_JZ, OP_JC, OP_JB, OP_JBC: tk = eq;
         default:                     tk = ~eq;
      endcase
      return tk;
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  rel_q, rel_d;
   logic [15:0] pc_q, pc_d;
   logic [1:0]  comp_sel_q, comp_sel_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        take_q, take_d;
   logic [15:0] target_q, target_d;
   logic        bit_clr_q, bit_clr_d;
   logic        err_q, err_d;
   logic        finish_s, fin_take_s, fin_err_s;
`ifdef OC8051_BRANCH_TIMEOUT_EN
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
   logic [3:0]  cnt_q, cnt_d;
`endif

   // Next-state and output computation.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rel_d      = rel_q;
      pc_d       = pc_q;
      comp_sel_d = comp_sel_q;
      done_d     = 1'b0;
      take_d     = take_q;
      target_d   = target_q;
      bit_clr_d  = bit_clr_q;
      err_d      = err_q;
      finish_s   = 1'b0;
      fin_take_s = 1'b0;
      fin_err_s  = 1'b0;
`ifdef OC8051_BRANCH_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               op_d       = op_i;
               rel_d      = rel_i;
               pc_d       = pc_i;
               comp_sel_d = sel_of(op_i);
               // op[2] set = operand class (JB/JNB/JBC/JDES)
               state_d    = op_i[2] ? ST_WAIT : ST_SEL;
`ifdef OC8051_BRANCH_TIMEOUT_EN
               cnt_d      = 4'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEL: begin
            finish_s   = 1'b1;
            fin_take_s = take_of(op_q, eq_i);
         end
         ST_WAIT: begin
            if (opnd_vld_i) begin
               if ((op_q == OP_JBC) && eq_i) begin
                  state_d   = ST_CLR;
                  bit_clr_d = 1'b1;
`ifdef OC8051_BRANCH_TIMEOUT_EN
                  cnt_d     = 4'd0;
`endif
               end else begin
                  finish_s   = 1'b1;
                  fin_take_s = take_of(op_q, eq_i);
               end
            end else begin
`ifdef OC8051_BRANCH_TIMEOUT_EN
               if (cnt_q == TO_LAST) begin
                  finish_s   = 1'b1;
                  fin_take_s = 1'b0;
                  fin_err_s  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
`else
               state_d = ST_WAIT;
`endif
            end
         end
         ST_CLR: begin
            // Reaching CLR already means the JBC branch is taken.
            if (clr_ack_i) begin
               bit_clr_d  = 1'b0;
               finish_s   = 1'b1;
               fin_take_s = 1'b1;
            end else begin
`ifdef OC8051_BRANCH_TIMEOUT_EN
               if (cnt_q == TO_LAST) begin
                  bit_clr_d  = 1'b0;
                  finish_s   = 1'b1;
                  fin_take_s = 1'b1;
                  fin_err_s  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
`else
               state_d = ST_CLR;
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            bit_clr_d = 1'b0;
         end
      endcase

      if (finish_s) begin
         state_d  = ST_DONE;
         done_d   = 1'b1;
         take_d   = fin_take_s;
         err_d    = fin_err_s;
         target_d = pc_q + {{8{rel_q[7]}}, rel_q};
      end else begin
         target_d = target_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         op_q       <= 3'd0;
         rel_q      <= 8'h00;
         pc_q       <= 16'h0000;
         comp_sel_q <= 2'b00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         take_q     <= 1'b0;
         target_q   <= 16'h0000;
         bit_clr_q  <= 1'b0;
         err_q      <= 1'b0;
`ifdef OC8051_BRANCH_TIMEOUT_EN
         cnt_q      <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rel_q      <= rel_d;
         pc_q       <= pc_d;
         comp_sel_q <= comp_sel_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         take_q     <= take_d;
         target_q   <= target_d;
         bit_clr_q  <= bit_clr_d;
         err_q      <= err_d;
`ifdef OC8051_BRANCH_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign comp_sel_o = comp_sel_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign take_o     = take_q;
   assign target_o   = target_q;
   assign bit_clr_o  = bit_clr_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_oc8051_branch_ctrl.sv
// Randomized scoreboard bench for oc8051_branch_ctrl.
module tb_oc8051_branch_ctrl;

   localparam int TO_TB = 3;
`ifdef OC8051_BRANCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, eq, opnd_vld, clr_ack;
   logic [2:0]  op;
   logic [7:0]  rel;
   logic [15:0] pc;
   logic [1:0]  comp_sel;
   logic        busy, done, take, bit_clr, err;
   logic [15:0] target;

   typedef struct packed {
      logic        take;
      logic [15:0] target;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   oc8051_branch_ctrl #(.TIMEOUT(TO_TB)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .rel_i(rel),
      .pc_i(pc), .comp_sel_o(comp_sel), .eq_i(eq), .opnd_vld_i(opnd_vld),
      .clr_ack_i(clr_ack), .busy_o(busy), .done_o(done), .take_o(take),
      .target_o(target), .bit_clr_o(bit_clr), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_done actual=1 required=0");
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_take", take, mon_e.take);
            chk("sb_target", target, mon_e.target);
            chk("sb_err", err, mon_e.err);
         end
      end
   end

   // One branch: o/r/p/e = op, rel, pc, comparator value; n = cycle of opnd_vld,
   // gap = CLR cycles before clr_ack, stray = cycle of an extra (ignored) start.
   task automatic run_op(input logic [2:0] o, input logic [7:0] r, input logic [15:0] p,
                         input logic e, input int n, input int gap, input int stray);
      logic imm, tk, er, clr_path, clr_abort, wait_abort;
      logic [1:0] xsel;
      logic [15:0] tgt;
      exp_t x;
      int s, done_c, m, bit_end;
      imm = (o < 3'd4);
      case (o)
         3'd0, 3'd1: xsel = 2'b00;
         3'd2, 3'd3: xsel = 2'b10;
         3'd7:       xsel = 2'b01;
         default:    xsel = 2'b11;
      endcase
      s = int'(r);
      if (s >= 128) s = s - 256;
      tgt = 16'((int'(p) + s + 65536) % 65536);
      tk = (o inside {3'd0, 3'd2, 3'd4, 3'd6}) ? e : ~e;
      er = 1'b0; clr_path = 1'b0; clr_abort = 1'b0; m = -1; bit_end = -1;
      wait_abort = !imm && TO_EN && (n > TO_TB);
      if (imm) begin
         done_c = 2;
      end else if (wait_abort) begin
         done_c = TO_TB + 1; tk = 1'b0; er = 1'b1;
      end else if (o == 3'd6 && e) begin
         clr_path = 1'b1; tk = 1'b1;
         m = n + 1 + gap;
         clr_abort = TO_EN && (gap >= TO_TB);
         if (clr_abort) begin
            done_c = n + 1 + TO_TB; bit_end = n + TO_TB; er = 1'b1;
         end else begin
            done_c = m + 1; bit_end = m;
         end
      end else begin
         done_c = n + 1;
      end
      x.take = tk; x.target = tgt; x.err = er;
      exp_q.push_back(x);
      for (int c = 0; c <= done_c + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("idle_busy", busy, 0);
         end else begin
            chk("busy", busy, (c <= done_c));
            chk("done_cycle", done, (c == done_c));
            chk("comp_sel", comp_sel, xsel);
            chk("bit_clr", bit_clr, (clr_path && c >= n + 1 && c <= bit_end));
         end
         if (c == done_c + 1) begin
            chk("hold_take", take, tk);
            chk("hold_target", target, tgt);
            chk("hold_err", err, er);
         end
         start = (c == 0) || (stray != 0 && c == stray);
         if (c == 0) begin
            op = o; rel = r; pc = p;
         end else begin
            op = 3'($urandom); rel = 8'($urandom); pc = 16'($urandom);
         end
         eq = 1'($urandom);
         if (imm && c == 1) eq = e;
         if (!imm && c == n) eq = e;
         opnd_vld = imm ? 1'($urandom) : (!wait_abort && c == n);
         clr_ack  = clr_path && !clr_abort && (c == m);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'd0; rel = 8'h00; pc = 16'h0000;
      eq = 1'b0; opnd_vld = 1'b0; clr_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_take", take, 0);
      chk("rst_err", err, 0);
      chk("rst_bit_clr", bit_clr, 0);
      chk("rst_comp_sel", comp_sel, 0);
      chk("rst_target", target, 16'h0000);
      rst_n = 1'b1;

      run_op(3'd0, 8'h10, 16'h0100, 1'b1, 1, 0, 0);   // JZ  -> 0x0110 taken
      run_op(3'd3, 8'hFE, 16'h0000, 1'b1, 1, 0, 0);   // JNC -> 0xFFFE not taken
      run_op(3'd4, 8'h20, 16'h1000, 1'b1, 4, 0, 0);   // JB, opnd_vld at cycle 4
      run_op(3'd6, 8'h03, 16'h0200, 1'b1, 2, 2, 4);   // JBC clr_ack cycle 5, stray start 4
      run_op(3'd0, 8'h20, 16'hFFF0, 1'b0, 1, 0, 2);   // wrap to 0x0010, start in DONE
      run_op(3'd1, 8'hF0, 16'h0005, 1'b0, 1, 0, 0);   // wrap to 0xFFF5
      run_op(3'd6, 8'h40, 16'h3000, 1'b1, 1, 6, 0);   // long CLR (aborts when enabled)
      run_op(3'd7, 8'h7F, 16'h2000, 1'b0, 3, 0, 0);   // JDES des!=0 taken

      // Reset in the middle of WAIT: outputs clear at once and no done follows.
      @(negedge clk);
      start = 1'b1; op = 3'd7; rel = 8'h11; pc = 16'h4000; opnd_vld = 1'b0; clr_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_target", target, 16'h0000);
      chk("mid_rst_take", take, 0);
      chk("mid_rst_comp_sel", comp_sel, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         opnd_vld = 1'($urandom); eq = 1'($urandom);
         chk("post_rst_busy", busy, 0);
      end
      opnd_vld = 1'b0;

      for (int i = 0; i < 150; i++) begin
         int n, gap, stray;
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 7) == 0) n = $urandom_range(3, 7);
         gap = $urandom_range(0, 4);
         stray = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : 0;
         run_op(3'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), n, gap, stray);
      end

      // JNB with no operand for 100 cycles: busy throughout, or timeout abort.
      run_op(3'd5, 8'h01, 16'h0001, 1'b0, 100, 0, 0);

      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
